// File: rtl/heroe_disp_pkg.sv
// Shared display definitions: game-state codes, 7-segment glyphs (bit6=a .. bit0=g),
// the message ROM and the scroller FSM state type.
package heroe_disp_pkg;

    localparam logic [2:0] ST_OFF  = 3'd0;
    localparam logic [2:0] ST_WLCM = 3'd1;
    localparam logic [2:0] ST_CH   = 3'd2;
    localparam logic [2:0] ST_GAME = 3'd3;
    localparam logic [2:0] ST_WL   = 3'd4;
    localparam logic [2:0] ST_PA   = 3'd5;

    localparam logic [6:0] G_BLANK = 7'h00;
    localparam logic [6:0] G_A     = 7'h77;
    localparam logic [6:0] G_C     = 7'h4E;
    localparam logic [6:0] G_E     = 7'h4F;
    localparam logic [6:0] G_G     = 7'h5E;
    localparam logic [6:0] G_H     = 7'h37;
    localparam logic [6:0] G_L     = 7'h0E;
    localparam logic [6:0] G_N     = 7'h15;
    localparam logic [6:0] G_O     = 7'h7E;
    localparam logic [6:0] G_R     = 7'h05;
    localparam logic [6:0] G_S     = 7'h5B;
    localparam logic [6:0] G_T     = 7'h0F;
    localparam logic [6:0] G_DASH  = 7'h01;

    // Message positions carry one spare bit so idx+3 never wraps back to glyph 0.
    localparam int unsigned MSG_IW = 5;

    typedef enum logic [2:0] {
        SCR_LOAD,
        SCR_STATIC,
        SCR_HOLD_S,
        SCR_SHIFT,
        SCR_HOLD_E
    } scr_state_e;

    function automatic logic [MSG_IW-1:0] msg_len(input logic [2:0] st);
        logic [MSG_IW-1:0] len;
        case (st)
            ST_WLCM: len = 5'd12;
            ST_CH:   len = 5'd4;
            ST_WL:   len = 5'd8;
            default: len = 5'd0;
        endcase
        return len;
    endfunction

    function automatic logic [6:0] msg_glyph(input logic [2:0] st, input logic [MSG_IW-1:0] i);
        logic [6:0] g;
        g = G_BLANK;
        if (i < msg_len(st)) begin
            case (st)
                ST_WLCM: begin // "HOLA HErOE -"
                    case (i)
                        5'd0:    g = G_H;
                        5'd1:    g = G_O;
                        5'd2:    g = G_L;
                        5'd3:    g = G_A;
                        5'd4:    g = G_BLANK;
                        5'd5:    g = G_H;
                        5'd6:    g = G_E;
                        5'd7:    g = G_R;
                        5'd8:    g = G_O;
                        5'd9:    g = G_E;
                        5'd10:   g = G_BLANK;
                        5'd11:   g = G_DASH;
                        default: g = G_BLANK;
                    endcase
                end
                ST_CH: begin // "HErO"
                    case (i)
                        5'd0:    g = G_H;
                        5'd1:    g = G_E;
                        5'd2:    g = G_R;
                        5'd3:    g = G_O;
                        default: g = G_BLANK;
                    endcase
                end
                ST_WL: begin // "GAnAStE "
                    case (i)
                        5'd0:    g = G_G;
                        5'd1:    g = G_A;
                        5'd2:    g = G_N;
                        5'd3:    g = G_A;
                        5'd4:    g = G_S;
                        5'd5:    g = G_T;
                        5'd6:    g = G_E;
                        5'd7:    g = G_BLANK;
                        default: g = G_BLANK;
                    endcase
                end
                default: g = G_BLANK;
            endcase
        end
        return g;
    endfunction

endpackage

// File: rtl/menu_scroller_step_tick.sv
// Scroll-rate divider: a one-cycle tick after every STEP_DIV enabled cycles.
// clr restarts the count and suppresses any tick in the same cycle.
module step_tick #(
    parameter int unsigned STEP_DIV = 6_750_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(STEP_DIV);

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap = (cnt_q == CW'(STEP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= wrap ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = en && !clr && wrap;

endmodule

// File: rtl/menu_scroller.sv
// 4-glyph text field sequencer for the display mux: picks the message for the current
// game state and scrolls long ones. Optional BLINK_EN macro blinks the WL message.
module menu_scroller
    import heroe_disp_pkg::*;
#(
    parameter int unsigned STEP_DIV   = 6_750_000,
    parameter int unsigned HOLD_STEPS = 4,
    parameter int unsigned MAX_LEN    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  presente,
    input  logic        restart,
    input  logic        scroll_en,
    output logic [27:0] display_menu,
    output logic        busy,
    output logic        pass_done
);

    localparam int unsigned IW = $clog2(MAX_LEN);

    scr_state_e         state_q;
    logic [IW-1:0]      idx_q;
    logic [3:0]         hold_q;
    logic [2:0]         presente_q;
    logic [27:0]        window_q;
    logic               busy_q;
    logic               pass_done_q;

    logic               change;
    logic               tick;
    logic               hold_last;
    logic               scrolls;
    logic [IW-1:0]      idx_inc;
    logic [MSG_IW-1:0]  cur_len;
    logic [MSG_IW-1:0]  last_idx;

    // Four consecutive glyphs from base; positions past the message end read blank.
    function automatic logic [27:0] window_at(input logic [2:0] st, input logic [IW-1:0] base);
        logic [27:0] w;
        logic [IW:0] pos;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            pos = {1'b0, base} + (IW+1)'(k);
            w[27-7*k -: 7] = msg_glyph(st, MSG_IW'(pos));
        end
        return w;
    endfunction

    assign change    = (presente != presente_q) || (restart && (state_q != SCR_LOAD));
    assign cur_len   = msg_len(presente_q);
    assign last_idx  = cur_len - MSG_IW'(4);
    assign scrolls   = (cur_len > MSG_IW'(4));
    assign idx_inc   = idx_q + IW'(1);
    assign hold_last = (hold_q == 4'(HOLD_STEPS - 1));

    step_tick #(
        .STEP_DIV(STEP_DIV)
    ) u_step_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (scroll_en),
        .clr  (change || (state_q == SCR_LOAD)),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCR_LOAD;
            idx_q       <= '0;
            hold_q      <= '0;
            presente_q  <= ST_OFF;
            window_q    <= '0;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            presente_q  <= presente;
            pass_done_q <= 1'b0;
            if (change) begin
                state_q <= SCR_LOAD;
            end else begin
                case (state_q)
                    SCR_LOAD: begin
                        idx_q    <= '0;
                        hold_q   <= '0;
                        window_q <= window_at(presente_q, '0);
                        busy_q   <= scrolls;
                        state_q  <= scrolls ? SCR_HOLD_S : SCR_STATIC;
                    end
                    SCR_STATIC: ;
                    SCR_HOLD_S: begin
                        if (tick) begin
                            if (hold_last) begin
                                hold_q  <= '0;
                                state_q <= SCR_SHIFT;
                            end else begin
                                hold_q <= hold_q + 4'd1;
                            end
                        end
                    end
                    SCR_SHIFT: begin
                        if (tick) begin
                            idx_q    <= idx_inc;
                            window_q <= window_at(presente_q, idx_inc);
                            if (MSG_IW'(idx_inc) == last_idx) begin
                                state_q <= SCR_HOLD_E;
                            end
                        end
                    end
                    SCR_HOLD_E: begin
                        if (tick) begin
                            if (hold_last) begin
                                hold_q      <= '0;
                                idx_q       <= '0;
                                window_q    <= window_at(presente_q, '0);
                                pass_done_q <= 1'b1;
                                state_q     <= SCR_HOLD_S;
                            end else begin
                                hold_q <= hold_q + 4'd1;
                            end
                        end
                    end
                    default: state_q <= SCR_LOAD;
                endcase
            end
        end
    end

`ifdef BLINK_EN
    logic blink_off_q;

    // Phase restarts visible when a message is actually loaded, then flips on every tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_off_q <= 1'b0;
        end else if ((state_q == SCR_LOAD) && !change) begin
            blink_off_q <= 1'b0;
        end else if (tick && (presente_q == ST_WL)) begin
            blink_off_q <= ~blink_off_q;
        end
    end

    assign display_menu = blink_off_q ? 28'd0 : window_q;
`else
    assign display_menu = window_q;
`endif

    assign busy      = busy_q;
    assign pass_done = pass_done_q;

endmodule

// File: tb/tb_menu_scroller.sv
// Directed bench for menu_scroller: a tick-count model predicts outputs every cycle,
// and hand-computed windows pin the model at key points.
module tb_menu_scroller;

    localparam int STEP_DIV   = 4;
    localparam int HOLD_STEPS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  presente = 3'd1;
    logic        restart = 1'b0;
    logic        scroll_en = 1'b1;
    logic [27:0] display_menu;
    logic        busy;
    logic        pass_done;

    int n_tests = 0;
    int n_fail  = 0;

    menu_scroller #(
        .STEP_DIV  (STEP_DIV),
        .HOLD_STEPS(HOLD_STEPS),
        .MAX_LEN   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .presente    (presente),
        .restart     (restart),
        .scroll_en   (scroll_en),
        .display_menu(display_menu),
        .busy        (busy),
        .pass_done   (pass_done)
    );

    always #5 clk = ~clk;

    // ---------------- message text, written out independently ----------------
    logic [6:0] wlcm_g [12] = '{7'h37, 7'h7E, 7'h0E, 7'h77, 7'h00, 7'h37,
                                7'h4F, 7'h05, 7'h7E, 7'h4F, 7'h00, 7'h01};
    logic [6:0] ch_g   [4]  = '{7'h37, 7'h4F, 7'h05, 7'h7E};
    logic [6:0] wl_g   [8]  = '{7'h5E, 7'h77, 7'h15, 7'h77, 7'h5B, 7'h0F, 7'h4F, 7'h00};

    function automatic int len_of(input int st);
        case (st)
            1: return 12;
            2: return 4;
            4: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [6:0] glyph(input int st, input int i);
        if (i >= len_of(st)) return 7'h00;
        case (st)
            1: return wlcm_g[i];
            2: return ch_g[i];
            4: return wl_g[i];
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [27:0] win(input int st, input int idx);
        return {glyph(st, idx), glyph(st, idx+1), glyph(st, idx+2), glyph(st, idx+3)};
    endfunction

    // Window start after t ticks of a scrolling message: hold, walk to len-4, hold, repeat.
    function automatic int idx_of(input int len, input int t);
        int p, r;
        p = 2*HOLD_STEPS + len - 4;
        r = t % p;
        if (r <= HOLD_STEPS) return 0;
        return (r - HOLD_STEPS < len - 4) ? r - HOLD_STEPS : len - 4;
    endfunction

    // ---------------- model ----------------
    int          m_prev = 0;
    int          m_st = 0;
    bit          m_loading = 1'b1;
    int          m_e = 0;
    int          m_t = 0;
    logic [27:0] m_win = '0;
    logic        m_busy = 1'b0;
    logic        m_pass = 1'b0;

    task automatic model_step();
        bit chg;
        int len;
        if (!rst_n) begin
            m_prev = 0; m_st = 0; m_loading = 1'b1; m_e = 0; m_t = 0;
            m_win = '0; m_busy = 1'b0; m_pass = 1'b0;
            return;
        end
        chg = (int'(presente) != m_prev) || (restart && !m_loading);
        m_pass = 1'b0;
        if (chg) begin
            m_loading = 1'b1;
            m_e = 0;
        end else if (m_loading) begin
            m_loading = 1'b0;
            m_st = m_prev;
            m_t = 0;
            m_e = 0;
            m_win = win(m_st, 0);
            m_busy = (len_of(m_st) > 4);
        end else if (scroll_en) begin
            m_e++;
            if (m_e == STEP_DIV) begin
                m_e = 0;
                m_t++;
                len = len_of(m_st);
                if (len > 4) begin
                    m_win = win(m_st, idx_of(len, m_t));
                    m_pass = ((m_t % (2*HOLD_STEPS + len - 4)) == 0);
                end
            end
        end
        m_prev = int'(presente);
    endtask

    function automatic logic [27:0] m_disp();
`ifdef BLINK_EN
        if (m_st == 4 && (m_t % 2) == 1) return 28'd0;
`endif
        return m_win;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check28(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check28("cyc_display", display_menu, m_disp());
            check28("cyc_busy", {27'd0, busy}, {27'd0, m_busy});
            check28("cyc_pass_done", {27'd0, pass_done}, {27'd0, m_pass});
        end
    end

    // ---------------- driver ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [27:0] W_WLCM0 = {7'h37, 7'h7E, 7'h0E, 7'h77};
    localparam logic [27:0] W_WLCM3 = {7'h77, 7'h00, 7'h37, 7'h4F};
    localparam logic [27:0] W_WLCM4 = {7'h00, 7'h37, 7'h4F, 7'h05};
    localparam logic [27:0] W_WLCM5 = {7'h37, 7'h4F, 7'h05, 7'h7E};
    localparam logic [27:0] W_WLCM8 = {7'h7E, 7'h4F, 7'h00, 7'h01};
    localparam logic [27:0] W_CH    = {7'h37, 7'h4F, 7'h05, 7'h7E};
    localparam logic [27:0] W_WL0   = {7'h5E, 7'h77, 7'h15, 7'h77};
    localparam logic [27:0] W_WL2   = {7'h15, 7'h77, 7'h5B, 7'h0F};

    initial begin
        int pass_cnt;
        int diff_cnt;
        int zero_cnt;

        // 1: reset, then WLCM scroll pass
        #1;
        check28("reset_display", display_menu, 28'd0);
        check28("reset_busy", {27'd0, busy}, 28'd0);
        check28("reset_pass", {27'd0, pass_done}, 28'd0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check28("wlcm_load_window", display_menu, W_WLCM0);
        check28("wlcm_busy", {27'd0, busy}, 28'd1);
        step(40);
        check28("wlcm_idx8", display_menu, W_WLCM8);
        step(7);
        check28("wlcm_hold_end_no_pass", {27'd0, pass_done}, 28'd0);
        step(1);
        check28("wlcm_pass_pulse", {27'd0, pass_done}, 28'd1);
        check28("wlcm_wrap_idx0", display_menu, W_WLCM0);
        step(1);
        check28("wlcm_pass_one_cycle", {27'd0, pass_done}, 28'd0);

        // 2: CH is static
        presente = 3'd2;
        step(2);
        check28("ch_window", display_menu, W_CH);
        check28("ch_busy", {27'd0, busy}, 28'd0);
        pass_cnt = 0;
        diff_cnt = 0;
        for (int i = 0; i < 100 * STEP_DIV; i++) begin
            step(1);
            if (pass_done) pass_cnt++;
            if (display_menu != W_CH) diff_cnt++;
        end
        check_int("ch_no_pass_done", pass_cnt, 0);
        check_int("ch_window_steady", diff_cnt, 0);

        // 3: change on a tick cycle at idx 5
        presente = 3'd1;
        step(2);
        check28("wlcm_reload", display_menu, W_WLCM0);
        step(28);
        check28("wlcm_idx5", display_menu, W_WLCM5);
        step(3);
        presente = 3'd4;
        step(1);
        check28("tick_discarded", display_menu, W_WLCM5);
        step(1);
        check28("wl_window", display_menu, W_WL0);
        step(8);
        check28("wl_full_hold", display_menu, W_WL0);
        step(8);
        check28("wl_idx2", display_menu, W_WL2);

        // 4: freeze at idx 3
        presente = 3'd1;
        step(2);
        step(20);
        check28("freeze_idx3", display_menu, W_WLCM3);
        scroll_en = 1'b0;
        diff_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (display_menu != W_WLCM3) diff_cnt++;
        end
        check_int("freeze_held", diff_cnt, 0);
        scroll_en = 1'b1;
        step(3);
        check28("reenable_before_tick", display_menu, W_WLCM3);
        step(1);
        check28("reenable_tick_idx4", display_menu, W_WLCM4);

        // restart pulse held into LOAD: second cycle is a no-op
        restart = 1'b1;
        step(2);
        restart = 1'b0;
        check28("restart_idx0", display_menu, W_WLCM0);

        // 5: async reset in the end hold
        step(42);
        #2;
        rst_n = 1'b0;
        #1;
        check28("async_rst_display", display_menu, 28'd0);
        check28("async_rst_busy", {27'd0, busy}, 28'd0);
        check28("async_rst_pass", {27'd0, pass_done}, 28'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
        check28("post_rst_no_early_load", display_menu, 28'd0);
        step(1);
        check28("post_rst_idx0", display_menu, W_WLCM0);
        check28("post_rst_busy", {27'd0, busy}, 28'd1);

        // 6: WL blink behaviour
        presente = 3'd4;
        step(2);
        check28("blink_first_visible", display_menu, W_WL0);
        zero_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (display_menu == 28'd0) zero_cnt++;
`ifdef BLINK_EN
            if (i == 4) check28("blink_off_phase", display_menu, 28'd0);
`else
            if (i == 4) check28("blink_off_phase", display_menu, W_WL0);
`endif
            if (i == 8) check28("blink_on_phase", display_menu, W_WL0);
        end
`ifdef BLINK_EN
        check_int("blink_zero_cycles", zero_cnt, 20);
`else
        check_int("blink_zero_cycles", zero_cnt, 0);
`endif

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
